// File: rtl/proc.sv
// Shared processor-wide parameters used across the issue/commit slice.
package proc;
  localparam int ROB_SLOTS    = 16;
  localparam int ROB_IDX_BITS = 4;
endpackage

// File: rtl/rob_ptr.sv
// Wrap-around pointer register: increments modulo 2**W, cleared by flush or reset.
module rob_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)      ptr_d = '0;
    else if (inc) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/rob_alloc.sv
// In-order ROB slot allocator: hands out tail tags, mirrors the ROB head from
// commit pulses, and tracks occupancy and per-slot busy bits.
module rob_alloc
  import proc::*;
#(
  parameter int ROB_SLOTS    = proc::ROB_SLOTS,
  parameter int ROB_IDX_BITS = proc::ROB_IDX_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    allocReq,
  output logic                    allocGnt,
  output logic [ROB_IDX_BITS-1:0] allocIdx,
  input  logic                    commit,
  output logic [ROB_IDX_BITS-1:0] headIdx,
  output logic [ROB_IDX_BITS:0]   count,
  output logic                    full,
  output logic                    empty,
  output logic [ROB_SLOTS-1:0]    busyVec,
  output logic                    commitErr
);
  localparam logic [ROB_IDX_BITS:0] SLOTS_CNT = (ROB_IDX_BITS+1)'(ROB_SLOTS);

  logic [ROB_IDX_BITS:0]   count_q, count_d;
  logic [ROB_SLOTS-1:0]    busy_q, busy_d;
  logic                    commit_err_q, commit_err_d;
  logic [ROB_IDX_BITS-1:0] tail, head;
  logic                    gnt, commit_ok;

  assign full  = (count_q == SLOTS_CNT);
  assign empty = (count_q == '0);

  // Full is judged on registered count only, so commit never reaches allocGnt.
  assign gnt       = allocReq && !full && !clear && !rst;
  assign commit_ok = commit && !empty && !clear && !rst;

  rob_ptr #(.W(ROB_IDX_BITS)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (gnt),
    .ptr (tail)
  );

  rob_ptr #(.W(ROB_IDX_BITS)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (commit_ok),
    .ptr (head)
  );

  always_comb begin
    count_d      = count_q;
    busy_d       = busy_q;
    commit_err_d = commit_err_q;
    if (clear) begin
      count_d = '0;
      busy_d  = '0;
    end else begin
      count_d = count_q + {{ROB_IDX_BITS{1'b0}}, gnt}
                        - {{ROB_IDX_BITS{1'b0}}, commit_ok};
      // head == tail only when empty or full, so set and clear never collide.
      if (gnt)       busy_d[tail] = 1'b1;
      if (commit_ok) busy_d[head] = 1'b0;
      if (commit && empty) commit_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      busy_q       <= '0;
      commit_err_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      busy_q       <= busy_d;
      commit_err_q <= commit_err_d;
    end
  end

  assign allocGnt  = gnt;
  assign allocIdx  = tail;
  assign headIdx   = head;
  assign count     = count_q;
  assign busyVec   = busy_q;
  assign commitErr = commit_err_q;
endmodule

// File: doc/rob_alloc.md
# rob_alloc

In-order allocator for reorder-buffer slots, sitting in the decode/issue stage in front of the ROB. Hands each dispatched instruction a `robIdx` tag in program order and tracks occupancy by mirroring the ROB head pointer from commit pulses. Stalls dispatch when all slots are in flight. Flushes to the empty state on `clear`, in lockstep with the ROB.

## Interface
- `ROB_SLOTS`, default `proc.ROB_SLOTS` (16): number of slots; must be a power of two.
- `ROB_IDX_BITS`, default `proc.ROB_IDX_BITS` (4): log2(`ROB_SLOTS`).

Ports:
- `clk` in 1: clock. Rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `clear` in 1: pipeline flush (exception/mispredict), same pulse the ROB receives.
- `allocReq` in 1: decode requests one slot this cycle.
- `allocGnt` out 1: slot granted this cycle.
- `allocIdx` out `ROB_IDX_BITS`: tag for the granted instruction (tail pointer).
- `commit` in 1: ROB retired its head slot this cycle (ROB head-valid).
- `headIdx` out `ROB_IDX_BITS`: oldest in-flight tag (mirrors ROB head).
- `count` out `ROB_IDX_BITS+1`: slots in flight.
- `full` out 1: `count == ROB_SLOTS`.
- `empty` out 1: `count == 0`.
- `busyVec` out `ROB_SLOTS`: bit i set while tag i is allocated and not yet committed.
- `commitErr` out 1: sticky; commit seen while empty.

## Operation
- State: `tail`, `head` (`ROB_IDX_BITS` each), `count`, `busyVec`, `commitErr`.
- Grant: `allocGnt = allocReq && !full && !clear && !rst`. `allocIdx = tail` at all times; it is meaningful only when `allocGnt` is high.
- On grant, `busyVec[tail]` is set and `tail` advances to `(tail+1) mod ROB_SLOTS` (natural wrap).
- On `commit` with `!empty`, `busyVec[head]` is cleared and `head` advances with wrap.
- On `commit` while empty, there is no state change and `commitErr` is set. It stays set until `rst`.
- Count: `count_next = count + allocGnt - (commit && !empty)`. A grant and a commit in the same cycle leave `count` unchanged; both pointers still advance.
- Full blocks a grant even if a commit arrives in the same cycle. This avoids a combinational path from `commit` to `allocGnt`. The freed slot is grantable the next cycle.
- Clear: `head`, `tail`, `count` and `busyVec` go to 0 next cycle, matching the ROB's head reset to 0. A `commit` in the clear cycle is ignored. `commitErr` is preserved.
- Invariant, checked by the bench: `popcount(busyVec) == count` and `tail == (head + count) mod ROB_SLOTS`.

## Timing
- Reset values: `allocIdx=0`, `headIdx=0`, `count=0`, `empty=1`, `full=0`, `busyVec=0`, `commitErr=0`, `allocGnt=0`.
- `allocGnt` is combinational from `allocReq` and registered `full`, within the same cycle.
- All other outputs are registered and update one cycle after the causing event.
- `rst` mid-operation overrides `clear`, `allocReq` and `commit` in the same cycle.
- A commit that arrives one cycle after a grant of the same tag is legal. `busyVec` is set, then cleared.

## Structure
- `ROB_SLOTS` and `ROB_IDX_BITS` come from the shared `proc` package. No new package constants are needed.
- One natural sub-module, `rob_ptr`: a wrap-around pointer register with `inc`, `clr` and `rst`. It is instantiated twice, for head and tail.
- Count, full/empty and `busyVec` logic stay in `rob_alloc`.

## Test plan
- Reset, then hold `allocReq=1` for 16 cycles. Required response:
  - grants with `allocIdx` 0..15;
  - `full=1` and `count=16` after the 16th grant;
  - the 17th request is not granted.
- From full, assert `commit` and `allocReq` in the same cycle. Required response:
  - no grant that cycle;
  - next cycle `headIdx=1`, `count=15`, grant with `allocIdx=0` (wrap).
- At `count=5`, drive grant and commit together for 20 cycles. Required response:
  - `count` stays 5;
  - `headIdx` and `allocIdx` wrap past 15 to 0;
  - `busyVec` popcount stays 5.
- With 7 in flight, pulse `clear` together with `allocReq` and `commit`. Required response:
  - no grant that cycle;
  - next cycle `count=0`, `head=tail=0`, `busyVec=0`, `empty=1`.
- In the empty state, pulse `commit`. Required response: `commitErr=1`, `count` stays 0; a later `clear` does not reset `commitErr`, but `rst` does.
- Random `allocReq`/`commit`/rare `clear` for 10k cycles against a reference model. Required response: the invariants hold every cycle, and tags are granted strictly in order.
